// File: rtl/jtframe_z80_romreq.sv
// Single-word ROM cache between a Z80 and the SDRAM controller: each 16-bit
// fetch serves two consecutive CPU bytes, and misses hold the CPU via rom_ok.
module jtframe_z80_romreq #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rom_cs,
    input  logic [AW-1:0] addr,
    input  logic          flush,
    output logic          rom_ok,
    output logic [7:0]    rom_data,
    output logic          sdram_req,
    output logic [AW-2:0] sdram_addr,
    input  logic          sdram_ok,
    input  logic [15:0]   sdram_data,
    output logic [7:0]    stall_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t        state;
    logic [15:0]   data;
    logic [AW-2:0] tag;
    logic          valid;
    logic          discard;
    logic          hit;

    assign hit      = valid && (tag == addr[AW-1:1]);
    assign rom_ok   = rom_cs && hit && (state == ST_IDLE);
    assign rom_data = addr[0] ? data[15:8] : data[7:0];

    // NOTE: every register here is updated with <= so all of them sample the
    // pre-edge values; blocking assignments would let later lines see new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            data       <= '0;
            tag        <= '0;
            valid      <= 1'b0;
            discard    <= 1'b0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            stall_cnt  <= '0;
        end else begin
            if (rom_cs && !rom_ok && stall_cnt != 8'hFF)
                stall_cnt <= stall_cnt + 8'd1;

            case (state)
                ST_IDLE: begin
                    // A flush that lands on a hit only clears valid; the miss
                    // is then seen on the following cycle.
                    if (flush)
                        valid <= 1'b0;
                    if (rom_cs && !hit) begin
                        sdram_req  <= 1'b1;
                        sdram_addr <= addr[AW-1:1];
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sdram_ok) begin
                        data      <= sdram_data;
                        tag       <= sdram_addr;
                        valid     <= ~(discard | flush);
                        discard   <= 1'b0;
                        sdram_req <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/jtframe_z80_romreq.md
JTFRAME_Z80_ROMREQ -- requirements
Module: jtframe_z80_romreq

Interface
REQ-001 Parameter AW, default 15, meaning ROM byte-address width; SDRAM word address is AW-1 bits.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rom_cs  input  1  CPU ROM chip select, from address decoder.
REQ-005 addr  input  AW  CPU byte address.
REQ-006 flush  input  1  invalidate cached word, e.g. after ROM download.
REQ-007 rom_ok  output  1  requested byte valid; drives the CPU wait gate.
REQ-008 rom_data  output  8  byte returned to the CPU.
REQ-009 sdram_req  output  1  word fetch request to the SDRAM controller.
REQ-010 sdram_addr  output  AW-1  word address of the fetch.
REQ-011 sdram_ok  input  1  one-cycle pulse: sdram_data valid, request complete.
REQ-012 sdram_data  input  16  fetched word; low byte is the even address.
REQ-013 stall_cnt  output  8  saturating count of CPU stall cycles.

Function
REQ-014 Block SHALL hold one cached 16-bit word: data register, tag (AW-1 bits) and valid flag.
REQ-015 hit = valid & (tag == addr[AW-1:1]); SHALL be combinational from registered state and current addr.
REQ-016 rom_ok SHALL equal rom_cs & hit & (state == IDLE), combinationally.
REQ-017 rom_data SHALL be data[15:8] when addr[0]=1, else data[7:0], combinationally; the value is defined only while rom_ok=1.
REQ-018 FSM states: IDLE and WAIT.
REQ-019 In IDLE with rom_cs=1 and hit=0, next edge SHALL: set sdram_req=1, latch sdram_addr=addr[AW-1:1], enter WAIT.
REQ-020 In IDLE with rom_cs=0 or hit=1, state SHALL remain IDLE and sdram_req SHALL stay 0.
REQ-021 In WAIT, sdram_req and sdram_addr SHALL hold steady until sdram_ok=1.
REQ-022 On sdram_ok in WAIT, the same edge SHALL load data=sdram_data, tag=sdram_addr, valid=~(discard|flush), sdram_req=0, discard=0, and enter IDLE.
REQ-023 sdram_ok in IDLE SHALL be ignored, with no state change.
REQ-024 Minimum miss latency SHALL be 2 cycles: one cycle to issue sdram_req, then sdram_ok on the following cycle at the earliest; rom_ok asserts the cycle after sdram_ok.
REQ-025 A change in addr or rom_cs during WAIT SHALL NOT abort the fetch; after the fetch returns, the new addr is re-evaluated in IDLE and misses again if the tag differs.
REQ-026 flush in IDLE SHALL clear valid on the next edge; with rom_cs=1 in that cycle, the cycle is treated as a miss on the following edge.
REQ-027 flush in WAIT SHALL set discard; the fetch SHALL complete but leave valid=0.
REQ-028 flush coincident with sdram_ok SHALL leave valid=0; flush has priority over fill.
REQ-029 A read whose addr differs from the tag only in addr[0] SHALL hit without an SDRAM access.
REQ-030 stall_cnt SHALL increment each cycle with rom_cs=1 & rom_ok=0, saturate at 255, and never wrap.

Reset
REQ-031 Reset SHALL take effect at the next rising edge when rst=1 and SHALL override all other inputs.
REQ-032 Reset values: state=IDLE, valid=0, discard=0, tag=0, data=0, sdram_req=0, sdram_addr=0, stall_cnt=0; hence rom_ok=0.
REQ-033 Reset during WAIT SHALL drop sdram_req on the next edge; a later sdram_ok SHALL be ignored per REQ-023.

Verification
REQ-034 Cold miss: reset, then rom_cs=1, addr=0x0123; sdram_ok with data 0xA55A two cycles later -> sdram_req=1 with sdram_addr=0x0091; after the fill, rom_ok=1 and rom_data=0xA5.
REQ-035 Byte-pair hit: after REQ-034 with addr=0x0122 -> rom_ok=1 in the same cycle, rom_data=0x5A, no sdram_req.
REQ-036 Address change in WAIT: miss on 0x0200; addr changed to 0x0400 before sdram_ok -> tag=0x100; one IDLE cycle, then new request with sdram_addr=0x200.
REQ-037 Flush races: (a) flush in WAIT -> valid=0 after the fill and a refetch follows; (b) flush on the same cycle as sdram_ok -> valid=0.
REQ-038 Stall saturation: rom_cs=1 on a miss with sdram_ok withheld for 300 cycles -> stall_cnt=255, sdram_req held at 1 throughout.
REQ-039 Reset mid-fetch: rst during WAIT -> sdram_req=0 next cycle; a following stray sdram_ok -> valid stays 0, rom_ok=0.
